uart_tx_serializer: RTL

//  UART byte transmitter. Consumes tx_start/tx_data from matrix_info_display (and the other

---
 rtl/uart_tx_serializer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   UART byte transmitter. It takes a byte on the rising edge of tx_start and
//   sends one frame on tx_pin: start bit, 8 data bits LSB first, an optional
//   parity bit, then 1 or 2 stop bits. tx_busy covers the whole frame, and
//   tx_done pulses for one cycle as tx_busy falls.
//
//   Because only the 0->1 edge of tx_start is acted on, a requester may hold
//   tx_start high until it sees tx_busy fall without causing a resend.
//
// Parameters
//   CLK_FREQ   system clock, Hz
//   BAUD_RATE  line rate, bit/s (CLK_FREQ/BAUD_RATE must be >= 2)
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   tx_start  send request (rising edge only)
//   tx_data   byte to send, sampled in the acceptance cycle
//   tx_busy   high for exactly one frame length, starting the cycle after accept
//   tx_done   one-cycle pulse in the cycle tx_busy falls
//   tx_pin    serial output, idles high
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_pin
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST = 3'd7;
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  // Configuration guards, evaluated at elaboration.
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_serializer: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;    // data bit index in DATA, stop bit index in STOP
  logic [7:0]       shift_reg;
  logic             par_bit;
  logic             start_d;

  logic accept;
  logic bit_end;

  // start_d resets to 1 so a tx_start held high across reset is not an edge.
  assign accept  = tx_start & ~start_d & (state == S_IDLE);
  assign bit_end = (baud_cnt == BIT_LAST);

  // Single FSM; tx_pin / tx_busy / tx_done are all registered and are loaded
  // on the transition into the state whose bit they represent, so the line
  // value changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      start_d   <= 1'b1;
      tx_pin    <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      start_d <= tx_start;
      tx_done <= 1'b0;

      // Bit timer free-runs 0..CLKS_PER_BIT-1 whenever a frame is in flight.
      if (state != S_IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          tx_pin  <= 1'b1;
          tx_busy <= 1'b0;
          if (accept) begin
            shift_reg <= tx_data;
            // Odd parity makes the total count of ones odd, even makes it even.
            par_bit   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            state     <= S_START;
            tx_pin    <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx_pin  <= shift_reg[0];
          end
        end

        S_DATA: begin
          if (bit_end) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state  <= S_PAR;
                tx_pin <= par_bit;
              end else begin
                state  <= S_STOP;
                tx_pin <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // Next bit is the one that will be at [0] after this shift.
              tx_pin  <= shift_reg[1];
            end
          end
        end

        S_PAR: begin
          if (bit_end) begin
            state   <= S_STOP;
            bit_idx <= '0;
            tx_pin  <= 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              state   <= S_IDLE;
              bit_idx <= '0;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          tx_pin  <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
